// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // rs1 is treated as signed by every op except the fully unsigned ones
    function automatic logic signedA(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is unsigned for MULHSU as well
    function automatic logic signedB(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_dp.sv
// Datapath for the multiply/divide sequencer: magnitude operands, shared
// {hi,lo} working register, one shift-add / restoring-divide step per cycle,
// and sign fix-up of the final value.
module ex_muldiv_dp
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            special,
    input  logic            step,
    input  logic            finish,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic [XLEN-1:0] result
);

    logic [2:0]      func3Q;
    logic            signAQ, signBQ, specQ;
    logic [XLEN-1:0] hiQ, loQ, opQ, specValQ, resultQ;

    logic            signA, signB;
    logic [XLEN-1:0] absA, absB, specVal;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            borrow;
    logic [XLEN-1:0] diffRem;
    logic [XLEN-1:0] stepHi, stepLo;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0] quotFix, remFix, finalVal;

    // Operand conditioning at acceptance; bypass value for b==0 and signed overflow
    always_comb begin
        signA = signedA(func3) & opA[XLEN-1];
        signB = signedB(func3) & opB[XLEN-1];
        absA  = signA ? -opA : opA;
        absB  = signB ? -opB : opB;
        if (opB == '0) begin
            specVal = func3[1] ? opA : '1;
        end else begin
            specVal = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration: lo holds multiplier/quotient, hi holds product-high/remainder
    always_comb begin
        sum     = {1'b0, hiQ} + (loQ[0] ? {1'b0, opQ} : '0);
        shifted = {hiQ, loQ[XLEN-1]};
        borrow  = shifted < {1'b0, opQ};
        // Remainder always stays below the divisor, so the low XLEN bits are exact
        diffRem = shifted[XLEN-1:0] - opQ;
        if (func3Q[2]) begin
            stepHi = borrow ? shifted[XLEN-1:0] : diffRem;
            stepLo = {loQ[XLEN-2:0], ~borrow};
        end else begin
            stepHi = sum[XLEN:1];
            stepLo = {sum[0], loQ[XLEN-1:1]};
        end
    end

    // Sign fix-up and half/quotient/remainder select
    always_comb begin
        prodFix = (signAQ ^ signBQ) ? -{hiQ, loQ} : {hiQ, loQ};
        quotFix = (signAQ ^ signBQ) ? -loQ : loQ;
        remFix  = signAQ ? -hiQ : hiQ;
        finalVal = '0;
        case (func3Q)
            F3_MUL:                       finalVal = prodFix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: finalVal = prodFix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              finalVal = quotFix;
            default:                      finalVal = remFix;
        endcase
        if (specQ) begin
            finalVal = specValQ;
        end
    end

    // Working registers and held result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            func3Q   <= '0;
            signAQ   <= 1'b0;
            signBQ   <= 1'b0;
            specQ    <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
            opQ      <= '0;
            specValQ <= '0;
            resultQ  <= '0;
        end else begin
            if (load) begin
                func3Q   <= func3;
                signAQ   <= signA;
                signBQ   <= signB;
                specQ    <= special;
                specValQ <= specVal;
                hiQ      <= '0;
                loQ      <= func3[2] ? absA : absB;
                opQ      <= func3[2] ? absB : absA;
            end else if (step) begin
                hiQ <= stepHi;
                loQ <= stepLo;
            end
            if (finish) begin
                resultQ <= finalVal;
            end
        end
    end

    assign result = finish ? finalVal : resultQ;

endmodule

// File: rtl/ex_muldiv_seq.sv
// Sequencer FSM for the iterative RV32M unit in E: accepts an M-op, stalls
// the front of the pipeline while iterating, then strobes the result once.
module ex_muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    state_t           stateQ;
    logic [CNT_W-1:0] cntQ;
    logic             accept, special, overflow, step;

    // Acceptance, special-divide detect and pipeline handshake
    always_comb begin
        accept   = (stateQ == S_IDLE) & start & ~flush;
        overflow = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = func3[2] & ((op_b == '0) | overflow);
        stall    = accept | (stateQ == S_BUSY);
        busy     = stateQ != S_IDLE;
        // flush kills the completing op so E->M keeps the ALU value
        result_valid = (stateQ == S_DONE) & ~flush;
        step     = (stateQ == S_BUSY) & ~flush;
    end

    // State and iteration counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= S_IDLE;
            cntQ   <= '0;
        end else begin
            unique case (stateQ)
                S_IDLE: begin
                    if (accept) begin
                        cntQ   <= '0;
                        stateQ <= special ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        stateQ <= S_IDLE;
                    end else if (cntQ == CNT_W'(XLEN - 1)) begin
                        stateQ <= S_DONE;
                    end else begin
                        cntQ <= cntQ + 1'b1;
                    end
                end
                S_DONE: begin
                    // start is still the same instruction here; never retrigger
                    stateQ <= S_IDLE;
                end
                default: stateQ <= S_IDLE;
            endcase
        end
    end

    ex_muldiv_dp u_dp (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .special (special),
        .step    (step),
        .finish  (result_valid),
        .func3   (func3),
        .opA     (op_a),
        .opB     (op_b),
        .result  (result)
    );

endmodule
